// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter of NUM_CH L1 miss/writeback channels onto one block-wide memory port.
// Optional macro CACHE_ARB_WR_PRIO_EN: pending writes win over all reads.
module cache_mem_arbiter #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH   = 512,
    parameter int unsigned TIMEOUT       = 1023,
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned AW = ADDRESS_WIDTH,
    localparam int unsigned BW = BLOCK_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_rd_req,
    input  logic [NUM_CH-1:0]    ch_wr_req,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH*BW-1:0] ch_wdata,
    input  logic [NUM_CH*BW-1:0] ch_wmask,
    output logic [BW-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]    ch_done,
    output logic [NUM_CH-1:0]    ch_err,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic                 MEM_data_read_enable,
    output logic                 MEM_data_write_enable,
    output logic [AW-1:0]        MEM_data_read_address,
    output logic [AW-1:0]        MEM_data_write_address,
    output logic [BW-1:0]        MEM_data_give,
    output logic [BW-1:0]        MEM_data_mask,
    input  logic [BW-1:0]        MEM_data_get,
    input  logic                 MEM_data_read_done,
    input  logic                 MEM_data_write_done
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, MEM_RD, MEM_WR, RESP, ABORT} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              is_wr_q, is_wr_d;
    logic [IW-1:0]     grant_d;
    logic [IW:0]       pick;
    logic              pick_is_wr;
    logic [IW-1:0]     pick_idx;
    logic [NUM_CH-1:0] grant_oh;
    logic              timeout_hit;
    logic              rd_en_d, wr_en_d, busy_d;
    logic [AW-1:0]     raddr_d, waddr_d;
    logic [BW-1:0]     give_d, mask_d, rdata_d;
    logic [NUM_CH-1:0] done_d, err_d;

    // Returns {found, index} of the first set bit of v scanning upward from ptr with wrap.
    function automatic logic [IW:0] rr_pick(input logic [NUM_CH-1:0] v, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            j = 32'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!res[IW] && v[IW'(j)]) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

`ifdef CACHE_ARB_WR_PRIO_EN
    logic [IW:0] pick_wr, pick_rd;
    always_comb begin
        pick_wr = rr_pick(ch_wr_req, rr_q);
        pick_rd = rr_pick(ch_rd_req, rr_q);
        if (pick_wr[IW]) begin
            pick       = pick_wr;
            pick_is_wr = 1'b1;
        end else begin
            pick       = pick_rd;
            pick_is_wr = 1'b0;
        end
    end
`else
    // A channel with both requests pending always issues its writeback first.
    always_comb begin
        pick       = rr_pick(ch_rd_req | ch_wr_req, rr_q);
        pick_is_wr = ch_wr_req[pick[IW-1:0]];
    end
`endif

    assign pick_idx    = pick[IW-1:0];
    assign grant_oh    = NUM_CH'(1) << grant_id;
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        is_wr_d = is_wr_q;
        grant_d = grant_id;
        rd_en_d = MEM_data_read_enable;
        wr_en_d = MEM_data_write_enable;
        raddr_d = MEM_data_read_address;
        waddr_d = MEM_data_write_address;
        give_d  = MEM_data_give;
        mask_d  = MEM_data_mask;
        rdata_d = ch_rdata;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick[IW]) begin
                    state_d = GRANT;
                    grant_d = pick_idx;
                    is_wr_d = pick_is_wr;
                    rr_d    = (pick_idx == IW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
                    raddr_d = ch_addr[pick_idx*AW +: AW];
                    waddr_d = ch_addr[pick_idx*AW +: AW];
                    give_d  = ch_wdata[pick_idx*BW +: BW];
                    mask_d  = ch_wmask[pick_idx*BW +: BW];
                end
            end
            GRANT: begin
                timer_d = '0;
                if (is_wr_q) begin
                    state_d = MEM_WR;
                    wr_en_d = 1'b1;
                end else begin
                    state_d = MEM_RD;
                    rd_en_d = 1'b1;
                end
            end
            MEM_RD: begin
                if (MEM_data_read_done) begin
                    state_d = RESP;
                    rd_en_d = 1'b0;
                    rdata_d = MEM_data_get;
                    done_d  = grant_oh;
                end else if (timeout_hit) begin
                    state_d = ABORT;
                    rd_en_d = 1'b0;
                    err_d   = grant_oh;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            MEM_WR: begin
                if (MEM_data_write_done) begin
                    state_d = RESP;
                    wr_en_d = 1'b0;
                    done_d  = grant_oh;
                end else if (timeout_hit) begin
                    state_d = ABORT;
                    wr_en_d = 1'b0;
                    err_d   = grant_oh;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                <= IDLE;
            rr_q                   <= '0;
            timer_q                <= '0;
            is_wr_q                <= 1'b0;
            grant_id               <= '0;
            busy                   <= 1'b0;
            MEM_data_read_enable   <= 1'b0;
            MEM_data_write_enable  <= 1'b0;
            MEM_data_read_address  <= '0;
            MEM_data_write_address <= '0;
            MEM_data_give          <= '0;
            MEM_data_mask          <= '0;
            ch_rdata               <= '0;
            ch_done                <= '0;
            ch_err                 <= '0;
        end else begin
            state_q                <= state_d;
            rr_q                   <= rr_d;
            timer_q                <= timer_d;
            is_wr_q                <= is_wr_d;
            grant_id               <= grant_d;
            busy                   <= busy_d;
            MEM_data_read_enable   <= rd_en_d;
            MEM_data_write_enable  <= wr_en_d;
            MEM_data_read_address  <= raddr_d;
            MEM_data_write_address <= waddr_d;
            MEM_data_give          <= give_d;
            MEM_data_mask          <= mask_d;
            ch_rdata               <= rdata_d;
            ch_done                <= done_d;
            ch_err                 <= err_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: 2-channel vector table plus timeout, reset and 3-channel wrap sequences.
module tb_cache_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 64;

    logic clk;
    logic rst;

    logic [1:0]      rd2, wr2, done2, err2;
    logic [2*AW-1:0] addr2;
    logic [2*BW-1:0] wdata2, wmask2;
    logic [BW-1:0]   rdata2, give2, mask2, get2;
    logic [0:0]      gid2;
    logic            busy2, ren2, wen2, rdone2, wdone2;
    logic [AW-1:0]   ra2, wa2;

    logic [2:0]      rd3, wr3, done3, err3;
    logic [3*AW-1:0] addr3;
    logic [3*BW-1:0] wdata3, wmask3;
    logic [BW-1:0]   rdata3, give3, mask3, get3;
    logic [1:0]      gid3;
    logic            busy3, ren3, wen3, rdone3, wdone3;
    logic [AW-1:0]   ra3, wa3;

    cache_mem_arbiter #(.NUM_CH(2), .ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW), .TIMEOUT(15)) u2 (
        .clk(clk), .rst(rst), .ch_rd_req(rd2), .ch_wr_req(wr2), .ch_addr(addr2),
        .ch_wdata(wdata2), .ch_wmask(wmask2), .ch_rdata(rdata2), .ch_done(done2), .ch_err(err2),
        .grant_id(gid2), .busy(busy2), .MEM_data_read_enable(ren2), .MEM_data_write_enable(wen2),
        .MEM_data_read_address(ra2), .MEM_data_write_address(wa2), .MEM_data_give(give2),
        .MEM_data_mask(mask2), .MEM_data_get(get2), .MEM_data_read_done(rdone2),
        .MEM_data_write_done(wdone2));

    cache_mem_arbiter #(.NUM_CH(3), .ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW), .TIMEOUT(15)) u3 (
        .clk(clk), .rst(rst), .ch_rd_req(rd3), .ch_wr_req(wr3), .ch_addr(addr3),
        .ch_wdata(wdata3), .ch_wmask(wmask3), .ch_rdata(rdata3), .ch_done(done3), .ch_err(err3),
        .grant_id(gid3), .busy(busy3), .MEM_data_read_enable(ren3), .MEM_data_write_enable(wen3),
        .MEM_data_read_address(ra3), .MEM_data_write_address(wa3), .MEM_data_give(give3),
        .MEM_data_mask(mask3), .MEM_data_get(get3), .MEM_data_read_done(rdone3),
        .MEM_data_write_done(wdone3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        int          lat;
        bit          drop;
        int          g;
        bit          w;
        logic [63:0] data;
    } vec_t;

    localparam int NV = 11;
    vec_t          vt [NV];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [AW-1:0] a_exp [2];
    logic [BW-1:0] w_exp [2];
    logic [BW-1:0] m_exp [2];
    logic [BW-1:0] last_rd;
    int            exp3 [4];

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t       v;
        logic [1:0] oh2;
        int         k;
        int         cnt;

        vt[0]  = '{2'b01, 2'b00, 4, 1'b0, 0, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
        vt[1]  = '{2'b10, 2'b00, 0, 1'b0, 1, 1'b0, 64'h1111_1111_1111_1111};
        vt[2]  = '{2'b11, 2'b00, 1, 1'b1, 0, 1'b0, 64'h2222_2222_2222_2222};
        vt[3]  = '{2'b11, 2'b00, 2, 1'b0, 1, 1'b0, 64'h3333_3333_3333_3333};
        vt[4]  = '{2'b11, 2'b00, 0, 1'b0, 0, 1'b0, 64'h4444_4444_4444_4444};
        vt[5]  = '{2'b11, 2'b00, 3, 1'b0, 1, 1'b0, 64'h5555_5555_5555_5555};
`ifdef CACHE_ARB_WR_PRIO_EN
        vt[6]  = '{2'b01, 2'b10, 2, 1'b0, 1, 1'b1, 64'h6666_6666_6666_6666};
        vt[7]  = '{2'b01, 2'b00, 1, 1'b0, 0, 1'b0, 64'h7777_7777_7777_7777};
`else
        vt[6]  = '{2'b01, 2'b10, 2, 1'b0, 0, 1'b0, 64'h6666_6666_6666_6666};
        vt[7]  = '{2'b00, 2'b10, 1, 1'b0, 1, 1'b1, 64'h7777_7777_7777_7777};
`endif
        vt[8]  = '{2'b11, 2'b01, 2, 1'b0, 0, 1'b1, 64'h8888_8888_8888_8888};
        vt[9]  = '{2'b11, 2'b00, 0, 1'b0, 1, 1'b0, 64'h9999_9999_9999_9999};
        vt[10] = '{2'b01, 2'b00, 1, 1'b0, 0, 1'b0, 64'hABCD_EF01_2345_6789};

        a_exp[0] = 32'h0000_0100;
        a_exp[1] = 32'h0000_2000;
        w_exp[0] = 64'h0123_4567_89AB_CDEF;
        w_exp[1] = 64'hFEDC_BA98_7654_3210;
        m_exp[0] = 64'hFFFF_0000_FFFF_0000;
        m_exp[1] = 64'h00FF_00FF_00FF_00FF;
        exp3     = '{0, 1, 2, 0};
        last_rd  = '0;

        rst    = 1'b0;
        rd2    = '0; wr2 = '0; rdone2 = 1'b0; wdone2 = 1'b0; get2 = '0;
        addr2  = {a_exp[1], a_exp[0]};
        wdata2 = {w_exp[1], w_exp[0]};
        wmask2 = {m_exp[1], m_exp[0]};
        rd3    = '0; wr3 = '0; rdone3 = 1'b0; wdone3 = 1'b0;
        get3   = 64'h3C3C_3C3C_C3C3_C3C3;
        addr3  = {32'h300, 32'h200, 32'h100};
        wdata3 = '0;
        wmask3 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy2), 64'(0));
        chk("rst_rd_en", 64'(ren2), 64'(0));
        chk("rst_wr_en", 64'(wen2), 64'(0));
        chk("rst_done_err", 64'({done2, err2}), 64'(0));
        chk("rst_grant_id", 64'(gid2), 64'(0));
        chk("rst_rdata", rdata2, 64'(0));
        chk("rst_busy3", 64'(busy3), 64'(0));
        rst = 1'b1;
        tick();

        // Vector table on the 2-channel instance
        for (int i = 0; i < NV; i++) begin
            v   = vt[i];
            rd2 = v.rd;
            wr2 = v.wr;
            tick();
            chk($sformatf("v%0d_grant_id", i), 64'(gid2), 64'(v.g));
            chk($sformatf("v%0d_busy", i), 64'(busy2), 64'(1));
            if (v.drop) begin
                rd2 = '0;
                wr2 = '0;
            end
            tick();
            chk($sformatf("v%0d_wr_en", i), 64'(wen2), 64'(v.w));
            chk($sformatf("v%0d_rd_en", i), 64'(ren2), 64'(!v.w));
            chk($sformatf("v%0d_addr", i), 64'(v.w ? wa2 : ra2), 64'(a_exp[v.g]));
            if (v.w) begin
                chk($sformatf("v%0d_give", i), give2, w_exp[v.g]);
                chk($sformatf("v%0d_mask", i), mask2, m_exp[v.g]);
            end
            for (int c = 0; c < v.lat; c++) begin
                rdone2 = v.w;
                wdone2 = !v.w;
                get2   = ~v.data;
                tick();
            end
            if (v.lat > 0) chk($sformatf("v%0d_early_done", i), 64'(done2), 64'(0));
            rdone2 = !v.w;
            wdone2 = v.w;
            get2   = v.data;
            tick();
            rdone2 = 1'b0;
            wdone2 = 1'b0;
            rd2    = '0;
            wr2    = '0;
            oh2    = 2'b01 << v.g;
            if (!v.w) last_rd = v.data;
            chk($sformatf("v%0d_ch_done", i), 64'(done2), 64'(oh2));
            chk($sformatf("v%0d_rdata", i), rdata2, last_rd);
            tick();
            chk($sformatf("v%0d_done_pulse", i), 64'(done2), 64'(0));
            chk($sformatf("v%0d_idle", i), 64'(busy2), 64'(0));
        end

        // Timeout: MEM never answers the read, stray write done present throughout
        rd2 = 2'b01;
        tick();
        chk("to_grant_id", 64'(gid2), 64'(0));
        tick();
        chk("to_rd_en", 64'(ren2), 64'(1));
        wdone2 = 1'b1;
        repeat (14) tick();
        chk("to_still_waiting", 64'({ren2, err2}), 64'(3'b100));
        rd2 = '0;
        tick();
        chk("to_ch_err", 64'(err2), 64'(2'b01));
        chk("to_enables", 64'({ren2, wen2}), 64'(0));
        chk("to_no_done", 64'(done2), 64'(0));
        tick();
        wdone2 = 1'b0;
        chk("to_err_pulse", 64'(err2), 64'(0));
        chk("to_idle", 64'(busy2), 64'(0));
        chk("to_rdata_held", rdata2, last_rd);

        // Reset asserted while a write is in flight
        wr2 = 2'b10;
        tick();
        tick();
        chk("rw_wr_en", 64'(wen2), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("rw_wr_en_cleared", 64'(wen2), 64'(0));
        chk("rw_busy", 64'(busy2), 64'(0));
        chk("rw_no_done", 64'({done2, err2}), 64'(0));
        wr2 = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        chk("rw_after_done", 64'({done2, err2}), 64'(0));
        chk("rw_after_busy", 64'(busy2), 64'(0));

        // 3 channels, all reads held: wrap order 0,1,2,0 with a stray write done always high
        rd3    = 3'b111;
        wdone3 = 1'b1;
        k      = 0;
        cnt    = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            tick();
            if (done3 != 3'b000) begin
                chk($sformatf("rr3_done%0d", k), 64'(done3), 64'(3'b001 << exp3[k]));
                chk($sformatf("rr3_gid%0d", k), 64'(gid3), 64'(exp3[k]));
                chk($sformatf("rr3_rdata%0d", k), rdata3, get3);
                k++;
            end
            if (ren3) cnt++;
            else cnt = 0;
            rdone3 = (cnt >= 2);
        end
        chk("rr3_grant_count", 64'(k), 64'(4));
        rd3    = '0;
        wdone3 = 1'b0;
        rdone3 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
